// File: rtl/ff_pkg.sv
// rtl/ff_pkg.sv - shared types and sizing constants for the FF layer-job scheduler
//
// Contents:
//   NUM_NEURONS, INPUT_SIZE    : layer geometry of the mac_unit engine
//   MIN_RUN_CYCLES             : worst-case legitimate mac_unit job length
//   DEFAULT_TIMEOUT_CYCLES     : watchdog limit, next power of two above MIN_RUN_CYCLES
//   sched_state_t              : scheduler FSM states
//   owner_t                    : job owner encoding (also the mac_owner wire encoding)
package ff_pkg;

    localparam int NUM_NEURONS    = 128;
    localparam int INPUT_SIZE     = 784;

    // Two passes over every weight plus one write-back per neuron.
    localparam int MIN_RUN_CYCLES = NUM_NEURONS * INPUT_SIZE * 2 + NUM_NEURONS;

    // Rounded up to a power of two so the watchdog is never tight against a
    // legitimate job (128/784 geometry gives 262144).
    localparam int DEFAULT_TIMEOUT_CYCLES = 1 << $clog2(MIN_RUN_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

    typedef enum logic {
        OWNER_INF = 1'b0,
        OWNER_TRN = 1'b1
    } owner_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant selection (combinational)
//
// Ports:
//   req[1:0]    in   request levels, [0] = inference, [1] = training
//   last_owner  in   owner of the most recent grant (owner_t encoding)
//   gnt_valid   out  at least one requester is asking
//   gnt_owner   out  owner that wins this cycle (owner_t encoding)
module rr_arbiter2
    import ff_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       gnt_valid,
    output logic       gnt_owner
);

    always_comb begin
        gnt_valid = |req;
        if (req == 2'b11) begin
            // Contention: the side that did not win last time goes now.
            gnt_owner = (last_owner == OWNER_INF) ? OWNER_TRN : OWNER_INF;
        end else begin
            gnt_owner = req[1] ? OWNER_TRN : OWNER_INF;
        end
    end

endmodule

// File: rtl/mac_job_scheduler.sv
// rtl/mac_job_scheduler.sv - shares one mac_unit between the inference and training paths
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   inf_req/inf_layer     inference job request (level) and its layer select
//   inf_gnt/inf_done      inference accept pulse / finish-or-abort pulse
//   trn_req/trn_layer     training job request (level) and its layer select
//   trn_gnt/trn_done      training accept pulse / finish-or-abort pulse
//   mac_start/mac_done    start pulse to mac_unit / its completion pulse
//   mac_layer/mac_owner   layer select and owner latched at grant
//   busy                  a job is between grant and its done pulse
//   err_timeout/err_clr   sticky watchdog-abort flag and its clear
module mac_job_scheduler
    import ff_pkg::*;
#(
    parameter int NUM_LAYERS     = 4,
    parameter int LAYER_W        = $clog2(NUM_LAYERS),
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int WDT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inf_req,
    input  logic [LAYER_W-1:0] inf_layer,
    output logic               inf_gnt,
    output logic               inf_done,
    input  logic               trn_req,
    input  logic [LAYER_W-1:0] trn_layer,
    output logic               trn_gnt,
    output logic               trn_done,
    output logic               mac_start,
    input  logic               mac_done,
    output logic [LAYER_W-1:0] mac_layer,
    output logic               mac_owner,
    output logic               busy,
    output logic               err_timeout,
    input  logic               err_clr
);

    sched_state_t     state;
    logic             last_owner;
    logic [WDT_W-1:0] wdt;

    logic             arb_valid;
    logic             arb_owner;
    logic             in_run;
    logic             timeout_hit;
    logic             err_set;

    rr_arbiter2 u_arb (
        .req        ({trn_req, inf_req}),
        .last_owner (last_owner),
        .gnt_valid  (arb_valid),
        .gnt_owner  (arb_owner)
    );

    assign in_run      = (state == RUN);
    assign timeout_hit = in_run && (wdt == WDT_W'(TIMEOUT_CYCLES - 1));
    // A completion arriving on the last allowed cycle is a real completion.
    assign err_set     = timeout_hit && !mac_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_owner  <= OWNER_TRN;
            wdt         <= '0;
            inf_gnt     <= 1'b0;
            trn_gnt     <= 1'b0;
            inf_done    <= 1'b0;
            trn_done    <= 1'b0;
            mac_start   <= 1'b0;
            mac_layer   <= '0;
            mac_owner   <= OWNER_INF;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            inf_gnt     <= 1'b0;
            trn_gnt     <= 1'b0;
            inf_done    <= 1'b0;
            trn_done    <= 1'b0;
            mac_start   <= 1'b0;
            err_timeout <= err_set | (err_timeout & ~err_clr);

            case (state)
                // RESP arbitrates like IDLE so a waiting request is granted
                // the cycle after the previous job's done pulse.
                IDLE, RESP: begin
                    if (arb_valid) begin
                        state      <= START;
                        busy       <= 1'b1;
                        mac_owner  <= arb_owner;
                        last_owner <= arb_owner;
                        mac_layer  <= (arb_owner == OWNER_TRN) ? trn_layer : inf_layer;
                        inf_gnt    <= (arb_owner == OWNER_INF);
                        trn_gnt    <= (arb_owner == OWNER_TRN);
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                START: begin
                    mac_start <= 1'b1;
                    wdt       <= '0;
                    state     <= RUN;
                end

                RUN: begin
                    wdt <= wdt + WDT_W'(1);
                    if (mac_done || timeout_hit) begin
                        state <= RESP;
                        if (mac_owner == OWNER_INF) begin
                            inf_done <= 1'b1;
                        end else begin
                            trn_done <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_job_scheduler.sv
// tb/tb_mac_job_scheduler.sv - self-checking bench for mac_job_scheduler
module tb_mac_job_scheduler;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       inf_req = 1'b0, trn_req = 1'b0, mac_done = 1'b0, err_clr = 1'b0;
    logic [1:0] inf_layer = 2'd0, trn_layer = 2'd0;
    logic       inf_gnt, inf_done, trn_gnt, trn_done, mac_start, mac_owner, busy, err_timeout;
    logic [1:0] mac_layer;

    mac_job_scheduler #(.NUM_LAYERS(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .inf_req(inf_req), .inf_layer(inf_layer), .inf_gnt(inf_gnt), .inf_done(inf_done),
        .trn_req(trn_req), .trn_layer(trn_layer), .trn_gnt(trn_gnt), .trn_done(trn_done),
        .mac_start(mac_start), .mac_done(mac_done), .mac_layer(mac_layer), .mac_owner(mac_owner),
        .busy(busy), .err_timeout(err_timeout), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: the current job as a timeline of cycle stamps.
    bit         m_has_job;
    int         m_g;          // cycle its gnt is visible
    int         m_end;        // cycle its done pulse is visible, -1 while unknown
    int         m_done_at;    // cycle the mac_unit model returns mac_done, -1 never
    logic       m_owner, m_last, m_err;
    logic [1:0] m_layer;

    // Stimulus controls.
    bit         pend_inf, pend_trn, rearm, rand_mode, clr_pulse, stray;
    logic [1:0] inf_layer_v, trn_layer_v;
    int         job_delay;

    // Observations of DUT activity.
    int         cur_t, obs_inf_gnt, obs_trn_gnt, obs_start, obs_inf_done;
    int         obs_start_layer, obs_start_owner, obs_trn_gnt_layer;
    int         n_trn_done, win_events, win_inf_done;
    logic       order[$];

    task automatic model_reset();
        m_has_job = 0; m_g = -100; m_end = -1; m_done_at = -1;
        m_owner = 1'b0; m_last = 1'b1; m_err = 1'b0; m_layer = 2'd0;
        obs_inf_gnt = -1000; obs_trn_gnt = -1000; obs_start = -1000; obs_inf_done = -1000;
        obs_start_layer = -1; obs_start_owner = -1; obs_trn_gnt_layer = -1;
        n_trn_done = 0; win_events = 0; win_inf_done = 0;
    endtask

    task automatic cycle_body();
        int   t, d;
        logic e_ig, e_tg, e_st, e_id, e_td, e_busy, in_run, err_set, new_owner;
        t = cyc;
        cur_t = t;
        e_ig   = m_has_job && (t == m_g) && !m_owner;
        e_tg   = m_has_job && (t == m_g) && m_owner;
        e_st   = m_has_job && (t == m_g + 1);
        e_id   = m_has_job && (m_end >= 0) && (t == m_end) && !m_owner;
        e_td   = m_has_job && (m_end >= 0) && (t == m_end) && m_owner;
        e_busy = m_has_job && (t >= m_g) && ((m_end < 0) || (t <= m_end));
        check("inf_gnt", inf_gnt, e_ig);
        check("trn_gnt", trn_gnt, e_tg);
        check("mac_start", mac_start, e_st);
        check("inf_done", inf_done, e_id);
        check("trn_done", trn_done, e_td);
        check("busy", busy, e_busy);
        check("mac_layer", mac_layer, m_layer);
        check("mac_owner", mac_owner, m_owner);
        check("err_timeout", err_timeout, m_err);

        if (inf_gnt) begin obs_inf_gnt = t; order.push_back(1'b0); end
        if (trn_gnt) begin obs_trn_gnt = t; obs_trn_gnt_layer = mac_layer; order.push_back(1'b1); end
        if (mac_start) begin obs_start = t; obs_start_layer = mac_layer; obs_start_owner = mac_owner; end
        if (inf_done) begin obs_inf_done = t; win_inf_done++; end
        if (trn_done) n_trn_done++;
        if (inf_gnt | trn_gnt | mac_start | inf_done | trn_done | busy) win_events++;

        // Stimulus for this cycle; a requester drops its req in its gnt cycle.
        in_run = m_has_job && (m_end < 0) && (t >= m_g + 1);
        if (e_ig) pend_inf = 0;
        if (e_tg) pend_trn = 0;
        if (rearm) begin
            if (!pend_inf && !e_ig) pend_inf = 1;
            if (!pend_trn && !e_tg) pend_trn = 1;
        end
        if (rand_mode) begin
            if (!pend_inf && !e_ig && $urandom_range(0, 5) == 0) begin
                pend_inf = 1; inf_layer_v = 2'($urandom_range(0, 3));
            end else if (pend_inf && $urandom_range(0, 7) == 0) begin
                inf_layer_v = 2'($urandom_range(0, 3));
            end
            if (!pend_trn && !e_tg && $urandom_range(0, 5) == 0) begin
                pend_trn = 1; trn_layer_v = 2'($urandom_range(0, 3));
            end else if (pend_trn && $urandom_range(0, 7) == 0) begin
                trn_layer_v = 2'($urandom_range(0, 3));
            end
            clr_pulse = ($urandom_range(0, 39) == 0);
            stray     = !in_run && ($urandom_range(0, 19) == 0);
        end
        inf_req   = pend_inf;
        trn_req   = pend_trn;
        inf_layer = inf_layer_v;
        trn_layer = trn_layer_v;
        mac_done  = ((m_done_at >= 0) && (t == m_done_at)) || stray;
        err_clr   = clr_pulse;

        // Model: what the inputs sampled at the end of this cycle imply.
        err_set = 1'b0;
        if (in_run) begin
            if (mac_done) begin
                m_end = t + 1;
            end else if (t == m_g + TO) begin
                m_end = t + 1;
                err_set = 1'b1;
            end
        end
        m_err = err_set | (m_err & ~err_clr);
        if ((!m_has_job || ((m_end >= 0) && (t >= m_end))) && (inf_req || trn_req)) begin
            new_owner = (inf_req && trn_req) ? ~m_last : trn_req;
            m_has_job = 1;
            m_g       = t + 1;
            m_end     = -1;
            m_owner   = new_owner;
            m_last    = new_owner;
            m_layer   = new_owner ? trn_layer : inf_layer;
            d         = rand_mode ? int'($urandom_range(0, TO + 3)) : job_delay;
            m_done_at = (d < 0) ? -1 : m_g + 1 + d;
        end
        clr_pulse = 0;
        stray     = 0;
    endtask

    task automatic step();
        @(negedge clk);
        cycle_body();
    endtask

    task automatic idle_steps(input int n);
        pend_inf = 0; pend_trn = 0;
        repeat (n) step();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        pend_inf = 0; pend_trn = 0;
        inf_req = 0; trn_req = 0; mac_done = 0; err_clr = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        cycle_body();
    endtask

    int base;

    initial begin
        rearm = 0; rand_mode = 0; clr_pulse = 0; stray = 0;
        inf_layer_v = 2'd0; trn_layer_v = 2'd0; job_delay = 4;
        model_reset();
        reset_dut();
        idle_steps(2);

        // Single inference job with fixed latencies.
        pend_inf = 1; inf_layer_v = 2'd2; job_delay = 8;
        step(); base = cur_t;
        repeat (14) step();
        check("t1_gnt_lat", obs_inf_gnt - base, 1);
        check("t1_start_lat", obs_start - base, 2);
        check("t1_start_layer", obs_start_layer, 2);
        check("t1_start_owner", obs_start_owner, 0);
        check("t1_done_lat", obs_inf_done - base, 11);
        check("t1_no_trn_done", n_trn_done, 0);

        // Continuous contention alternates, inf first after reset.
        reset_dut();
        order.delete();
        job_delay = 5; rearm = 1; pend_inf = 1; pend_trn = 1;
        repeat (34) step();
        rearm = 0;
        idle_steps(30);
        for (int i = 0; i < 4; i++)
            check($sformatf("rr_order%0d", i), (i < order.size()) ? 32'(order[i]) : 32'd2, 32'(i % 2));

        // Training request arriving while inference runs waits for its done.
        pend_inf = 1; inf_layer_v = 2'd1; job_delay = 6;
        step(); base = cur_t;
        repeat (3) step();
        pend_trn = 1; trn_layer_v = 2'd3; job_delay = 2;
        repeat (20) step();
        check("t3_inf_done_lat", obs_inf_done - base, 9);
        check("t3_trn_gnt_after_done", obs_trn_gnt - obs_inf_done, 1);
        check("t3_trn_layer", obs_trn_gnt_layer, 3);

        // Hung job: watchdog abort, clear, then a normal grant.
        pend_inf = 1; inf_layer_v = 2'd0; job_delay = -1;
        step(); base = cur_t;
        repeat (20) step();
        check("t4_abort_lat", obs_inf_done - base, 18);
        check("t4_err_set", err_timeout, 1);
        clr_pulse = 1;
        step(); step();
        check("t4_err_clr", err_timeout, 0);
        pend_trn = 1; job_delay = 3;
        step(); base = cur_t;
        repeat (10) step();
        check("t4_regrant_lat", obs_trn_gnt - base, 1);

        // Completion on the watchdog's last cycle, then a stray mac_done.
        pend_inf = 1; job_delay = TO - 1;
        step(); base = cur_t;
        repeat (20) step();
        check("t5_done_lat", obs_inf_done - base, 18);
        check("t5_err_clear", err_timeout, 0);
        win_events = 0;
        stray = 1;
        step();
        repeat (4) step();
        check("t5_stray_events", win_events, 0);

        // Reset in RUN with a training request pending.
        pend_inf = 1; job_delay = -1;
        step();
        repeat (5) step();
        pend_trn = 1; trn_layer_v = 2'd2;
        step();
        #2 rst = 1'b1;
        #1 check("rst_outputs", {inf_gnt, trn_gnt, inf_done, trn_done, mac_start, busy,
                                 err_timeout, mac_owner, mac_layer}, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        job_delay = 3;
        cycle_body(); base = cur_t;
        repeat (10) step();
        check("rst_trn_regrant_lat", obs_trn_gnt - base, 1);
        check("rst_trn_layer", obs_trn_gnt_layer, 2);
        check("rst_no_inf_done", win_inf_done, 0);

        // Randomized traffic against the model.
        rand_mode = 1;
        repeat (1500) step();
        rand_mode = 0;
        idle_steps(30);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
